// File: rtl/instr_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode_ctrl
//  Brief    : Multi-cycle fetch / decode / execute / write-back controller for
//             a 16-bit instruction set. Sequences an external instruction
//             memory, register file and ALU, and latches processor flags.
//  Option   : CTRL_HALT_ON_ILLEGAL_EN - when defined, an unsupported
//             instruction parks the controller in HALT until reset; otherwise
//             it is retired as a NOP.
//  Revision : 1.0  initial release
// ============================================================================
module instr_decode_ctrl #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [3:0]      rf_addr_a,
    output logic [3:0]      rf_addr_b,
    input  logic [15:0]     rf_data_a,
    input  logic [15:0]     rf_data_b,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    output logic [7:0]      alu_op,
    input  logic [15:0]     alu_c,
    input  logic [4:0]      alu_flags,
    output logic            rf_wr_en,
    output logic [3:0]      rf_wr_addr,
    output logic [15:0]     rf_wr_data,
    output logic [4:0]      psr,
    output logic            unsupported,
    output logic            halted
);

    localparam logic [2:0] c_fetch     = 3'd0;
    localparam logic [2:0] c_decode    = 3'd1;
    localparam logic [2:0] c_execute   = 3'd2;
    localparam logic [2:0] c_writeback = 3'd3;
    localparam logic [2:0] c_halt      = 3'd4;

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

`ifdef CTRL_HALT_ON_ILLEGAL_EN
    localparam logic c_halt_en = 1'b1;
`else
    localparam logic c_halt_en = 1'b0;
`endif

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [15:0]     r_op_a;
    logic [15:0]     r_op_b;
    logic [15:0]     r_res;
    logic [4:0]      r_flags;
    logic [4:0]      r_psr;
    logic            r_wr_en;
    logic            r_unsup;
    logic            r_halted;
    logic            r_live;

    logic [3:0]      w_eff_op;
    logic            w_unsup;
    logic            w_writes;
    logic            w_flag_op;
    logic            w_reg_src;
    logic            w_stop;

    // Instruction classification from the instruction register.
    assign w_eff_op  = (r_ir[15:12] == 4'b0000) ? r_ir[7:4] : r_ir[15:12];
    assign w_unsup   = (r_ir[15:12] == 4'b0100) || (r_ir[15:12] == 4'b1100);
    assign w_writes  = !w_unsup && (w_eff_op != 4'b1011);
    assign w_flag_op = (w_eff_op == 4'b0101) || (w_eff_op == 4'b1001) ||
                       (w_eff_op == 4'b1011);
    assign w_reg_src = (r_ir[15:12] == 4'b0000) || (r_ir[15:12] == 4'b1000);
    assign w_stop    = w_unsup && c_halt_en;

    // Datapath-facing outputs.
    assign imem_addr   = r_pc;
    assign rf_addr_a   = r_ir[11:8];
    assign rf_addr_b   = r_ir[3:0];
    assign alu_a       = r_op_a;
    assign alu_b       = w_reg_src ? r_op_b : {8'h00, r_ir[7:0]};
    assign rf_wr_en    = r_wr_en;
    assign rf_wr_addr  = r_ir[11:8];
    assign rf_wr_data  = r_res;
    assign psr         = r_psr;
    assign unsupported = r_unsup;
    assign halted      = r_halted;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; HALT is only entered when the halt option is built in.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_fetch:     if (imem_req && imem_ack) w_next = c_decode;
            c_decode:    w_next = c_execute;
            c_execute:   w_next = c_writeback;
            c_writeback: w_next = w_stop ? c_halt : c_fetch;
            c_halt:      w_next = c_halt;
            default:     w_next = c_fetch;
        endcase
    end

    // Per-state combinational outputs; the fetch request waits for the first
    // clock after reset so it can drop immediately when reset asserts.
    always_comb begin
        imem_req = 1'b0;
        alu_op   = 8'h00;
        case (r_state)
            c_fetch:   imem_req = r_live;
            c_execute: alu_op   = {r_ir[15:12], r_ir[7:4]};
            default:   ;
        endcase
    end

    // Instruction register and operand / result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live  <= 1'b0;
            r_ir    <= 16'h0000;
            r_op_a  <= 16'h0000;
            r_op_b  <= 16'h0000;
            r_res   <= 16'h0000;
            r_flags <= 5'b00000;
        end else begin
            r_live <= 1'b1;
            if (imem_req && imem_ack) begin
                r_ir <= imem_rdata;
            end
            if (r_state == c_decode) begin
                r_op_a <= rf_data_a;
                r_op_b <= rf_data_b;
            end
            if (r_state == c_execute) begin
                r_res   <= alu_c;
                r_flags <= alu_flags;
            end
        end
    end

    // Write-back strobes: registered so they are exactly one WRITEBACK cycle wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en  <= 1'b0;
            r_unsup  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_wr_en  <= (r_state == c_execute) && w_writes;
            r_unsup  <= (r_state == c_execute) && w_unsup;
            r_halted <= (w_next == c_halt);
        end
    end

    // Program counter and status flags retire at the end of WRITEBACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_psr <= 5'b00000;
        end else if (r_state == c_writeback) begin
            if (w_flag_op) begin
                r_psr <= r_flags;
            end
            if (!w_stop) begin
                r_pc <= r_pc + c_pc_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_decode_ctrl
//  Brief    : Directed self-checking bench for instr_decode_ctrl. Register
//             write-backs are checked against a scoreboard queue; a second
//             instance starting at PC 16'hFFFF exercises the wrap / illegal path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  rf_addr_a, rf_addr_b;
    logic [15:0] rf_data_a, rf_data_b;
    logic [15:0] alu_a, alu_b;
    logic [7:0]  alu_op;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic [4:0]  psr;
    logic        unsupported;
    logic        halted;

    logic        wrap_req;
    logic [15:0] wrap_addr;
    logic        wrap_ack;
    logic [15:0] wrap_rdata;
    logic [3:0]  wrap_ra, wrap_rb;
    logic [15:0] wrap_zero;
    logic [15:0] wrap_alu_a, wrap_alu_b;
    logic [7:0]  wrap_op;
    logic [4:0]  wrap_flags_in;
    logic        wrap_wr_en;
    logic [3:0]  wrap_wr_addr;
    logic [15:0] wrap_wr_data;
    logic [4:0]  wrap_psr;
    logic        wrap_unsup;
    logic        wrap_halted;

    logic [15:0] regs [16];

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } wb_t;
    wb_t sb [$];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_pc;
    logic [4:0]  exp_psr;

    always #5 clk = ~clk;

    assign rf_data_a = regs[rf_addr_a];
    assign rf_data_b = regs[rf_addr_b];

    instr_decode_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .rf_addr_a   (rf_addr_a),
        .rf_addr_b   (rf_addr_b),
        .rf_data_a   (rf_data_a),
        .rf_data_b   (rf_data_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .alu_flags   (alu_flags),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .psr         (psr),
        .unsupported (unsupported),
        .halted      (halted)
    );

    instr_decode_ctrl #(.PC_W(16), .RESET_PC(16'hFFFF)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (wrap_req),
        .imem_addr   (wrap_addr),
        .imem_ack    (wrap_ack),
        .imem_rdata  (wrap_rdata),
        .rf_addr_a   (wrap_ra),
        .rf_addr_b   (wrap_rb),
        .rf_data_a   (wrap_zero),
        .rf_data_b   (wrap_zero),
        .alu_a       (wrap_alu_a),
        .alu_b       (wrap_alu_b),
        .alu_op      (wrap_op),
        .alu_c       (wrap_zero),
        .alu_flags   (wrap_flags_in),
        .rf_wr_en    (wrap_wr_en),
        .rf_wr_addr  (wrap_wr_addr),
        .rf_wr_data  (wrap_wr_data),
        .psr         (wrap_psr),
        .unsupported (wrap_unsup),
        .halted      (wrap_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write-back pulse must match the oldest expected write.
    always @(negedge clk) begin
        wb_t e;
        if (rf_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {31'd0, rf_wr_en}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_addr", {28'd0, rf_wr_addr}, {28'd0, e.a});
                chk("wb_data", {16'd0, rf_wr_data}, {16'd0, e.d});
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // One full instruction through the main DUT, starting at a negedge.
    task automatic run_instr(input logic [15:0] instr, input logic [15:0] c,
                             input logic [4:0] fl, input int stall);
        logic [3:0]  top, eff;
        logic        unsup, wr, fop;
        logic [15:0] expb;
        wb_t         e;
        top   = instr[15:12];
        eff   = (top == 4'h0) ? instr[7:4] : top;
        unsup = (top == 4'h4) || (top == 4'hC);
        wr    = !unsup && (eff != 4'hB);
        fop   = (eff == 4'h5) || (eff == 4'h9) || (eff == 4'hB);
        expb  = (top == 4'h0 || top == 4'h8) ? regs[instr[3:0]] : {8'h00, instr[7:0]};

        wait_req();
        chk("imem_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
        end
        imem_rdata = instr;
        imem_ack   = 1'b1;
        alu_c      = c;
        alu_flags  = fl;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("dec_rf_addr_a", {28'd0, rf_addr_a}, {28'd0, instr[11:8]});
        chk("dec_rf_addr_b", {28'd0, rf_addr_b}, {28'd0, instr[3:0]});
        chk("dec_alu_op", {24'd0, alu_op}, 32'd0);
        chk("dec_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("ex_alu_op", {24'd0, alu_op}, {24'd0, instr[15:12], instr[7:4]});
        chk("ex_alu_a", {16'd0, alu_a}, {16'd0, regs[instr[11:8]]});
        chk("ex_alu_b", {16'd0, alu_b}, {16'd0, expb});
        if (wr) begin
            e.a = instr[11:8];
            e.d = c;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("wb_unsupported", {31'd0, unsupported}, {31'd0, unsup});
        @(negedge clk);
        exp_pc = exp_pc + 16'd1;
        if (fop) exp_psr = fl;
        chk("psr", {27'd0, psr}, {27'd0, exp_psr});
        chk("next_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
        chk("next_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
        alu_c         = 16'h0000;
        alu_flags     = 5'b00000;
        wrap_ack      = 1'b0;
        wrap_rdata    = 16'h4000;
        wrap_zero     = 16'h0000;
        wrap_flags_in = 5'b00000;
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        regs[1]  = 16'h0004;
        regs[2]  = 16'h0003;
        regs[5]  = 16'h1234;
        regs[10] = 16'hABCD;
        exp_pc   = 16'h0000;
        exp_psr  = 5'b00000;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", {16'd0, imem_addr}, 32'd0);
        chk("rst_psr", {27'd0, psr}, 32'd0);
        chk("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        chk("rst_unsup", {31'd0, unsupported}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_alu_op", {24'd0, alu_op}, 32'd0);
        reset = 1'b0;
        #1 chk("req_before_edge", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("req_first_edge", {31'd0, imem_req}, 32'd1);

        // ADD R2,R1 ; CMPI R1,-1 ; SUBI sets psr ; XOR leaves psr ; reg/imm variants
        run_instr(16'h0251, 16'h0007, 5'b00000, 0);
        run_instr(16'hB1FF, 16'h0000, 5'b01000, 0);
        chk("cmpi_psr", {27'd0, psr}, 32'b01000);
        run_instr(16'h9105, 16'hFFFF, 5'b00010, 2);
        run_instr(16'h0331, 16'h0002, 5'b11111, 0);
        chk("xor_psr_hold", {27'd0, psr}, 32'b00010);
        run_instr(16'h8A25, 16'h5A5A, 5'b10101, 1);
        run_instr(16'h5A80, 16'h0080, 5'b00001, 0);
        run_instr(16'h0BD5, 16'hBEEF, 5'b00100, 0);

        // Fetch stall then asynchronous reset in its third cycle
        wait_req();
        @(negedge clk);
        chk("hold_req_1", {31'd0, imem_req}, 32'd1);
        chk("hold_addr_1", {16'd0, imem_addr}, {16'd0, exp_pc});
        @(negedge clk);
        chk("hold_req_2", {31'd0, imem_req}, 32'd1);
        chk("hold_addr_2", {16'd0, imem_addr}, {16'd0, exp_pc});
        #2 reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_pc", {16'd0, imem_addr}, 32'd0);
        chk("async_rst_psr", {27'd0, psr}, 32'd0);
        exp_pc  = 16'h0000;
        exp_psr = 5'b00000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        run_instr(16'h0251, 16'h0007, 5'b00000, 0);

        // Illegal instruction at PC 16'hFFFF on the second instance
        chk("wrap_req", {31'd0, wrap_req}, 32'd1);
        chk("wrap_addr", {16'd0, wrap_addr}, 32'h0000FFFF);
        wrap_ack = 1'b1;
        @(negedge clk);
        wrap_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_unsup_pulse", {31'd0, wrap_unsup}, 32'd1);
        chk("wrap_no_write", {31'd0, wrap_wr_en}, 32'd0);
        @(negedge clk);
        chk("wrap_unsup_clear", {31'd0, wrap_unsup}, 32'd0);
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        chk("wrap_halted", {31'd0, wrap_halted}, 32'd1);
        chk("wrap_pc_hold", {16'd0, wrap_addr}, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_no_fetch", {31'd0, wrap_req}, 32'd0);
        end
        reset = 1'b1;
        #1 chk("halt_rst_clear", {31'd0, wrap_halted}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`else
        chk("wrap_not_halted", {31'd0, wrap_halted}, 32'd0);
        chk("wrap_pc_zero", {16'd0, wrap_addr}, 32'd0);
        chk("wrap_refetch", {31'd0, wrap_req}, 32'd1);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, meaning program counter width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port imem_req  output  1  instruction fetch request.
REQ-006 Port imem_addr  output  PC_W  fetch address, equal to the current PC.
REQ-007 Port imem_ack  input  1  fetch data valid this cycle.
REQ-008 Port imem_rdata  input  16  fetched instruction.
REQ-009 Port rf_addr_a, rf_addr_b  output  4 each  register-file read addresses (Rdest = instr[11:8], Rsrc = instr[3:0]).
REQ-010 Port rf_data_a, rf_data_b  input  16 each  register-file read data, valid one cycle after the address.
REQ-011 Port alu_a, alu_b  output  16 each  ALU operands.
REQ-012 Port alu_op  output  8  ALU opcode.
REQ-013 Port alu_c  input  16 and alu_flags  input  5  ALU result and flags {C,L,F,Z,N}.
REQ-014 Port rf_wr_en  output  1, rf_wr_addr  output  4, rf_wr_data  output  16  register write-back.
REQ-015 Port psr  output  5  latched processor status flags.
REQ-016 Port unsupported  output  1  one-cycle pulse on an unsupported instruction.
REQ-017 Port halted  output  1  high while the FSM is in HALT.

Function
REQ-018 The FSM SHALL have states FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-019 FETCH SHALL hold imem_req=1 with imem_addr stable until imem_ack=1, then latch imem_rdata into the instruction register and go to DECODE.
REQ-020 imem_ack while imem_req=0 SHALL be ignored.
REQ-021 DECODE SHALL drive rf_addr_a/rf_addr_b from the instruction register, latch rf_data_a/rf_data_b, and go to EXECUTE after exactly one cycle.
REQ-022 alu_op SHALL equal {instr[15:12], instr[7:4]} in EXECUTE, and SHALL be 8'h00 in all other states.
REQ-023 alu_a SHALL be the latched Rdest value.
REQ-024 alu_b SHALL be the latched Rsrc value when instr[15:12]=4'b0000 or 4'b1000, and {8'h00, instr[7:0]} otherwise.
REQ-025 EXECUTE SHALL capture alu_c and alu_flags in one cycle, then go to WRITEBACK.
REQ-026 WRITEBACK SHALL pulse rf_wr_en for one cycle with rf_wr_addr=instr[11:8] and rf_wr_data=the captured result.
REQ-027 rf_wr_en SHALL NOT assert for CMP/CMPI (effective op 4'b1011) or for unsupported instructions.
REQ-028 psr SHALL load the captured flags in WRITEBACK only for ADD/ADDI/SUB/SUBI/CMP/CMPI (effective op 0101, 1001 or 1011), and SHALL hold otherwise.
REQ-029 The effective op SHALL be instr[7:4] when instr[15:12]=0000, and instr[15:12] otherwise.
REQ-030 Unsupported instructions SHALL be those with instr[15:12]=4'b0100 or 4'b1100 (load/store/branch/jump).
REQ-031 In WRITEBACK the PC SHALL increment by 1 modulo 2^PC_W (all-ones wraps to 0), and the FSM SHALL return to FETCH.
REQ-032 Steady-state throughput SHALL be one instruction per 4 cycles plus fetch wait cycles.

Reset
REQ-033 Asserting reset in any state, including mid-fetch, SHALL asynchronously force state=FETCH and PC=RESET_PC.
REQ-034 Asserting reset SHALL asynchronously clear psr, the instruction register, the operand latches, rf_wr_en, unsupported and halted.
REQ-035 imem_req SHALL assert on the first rising edge after reset deasserts.

Configuration
REQ-036 With CTRL_HALT_ON_ILLEGAL_EN defined, an unsupported instruction SHALL pulse unsupported in WRITEBACK, leave the PC unchanged, and enter HALT (halted=1, no further fetches) until reset.
REQ-037 Without CTRL_HALT_ON_ILLEGAL_EN, an unsupported instruction SHALL pulse unsupported, execute as a NOP with PC+1, and the HALT state SHALL be unreachable.

Verification
REQ-038 Reset, then fetch 16'h0251 (ADD R2,R1) with R2=3, R1=4, alu_c=7 -> imem_addr=0, then rf_wr_en pulse with addr 2 and data 16'h0007, then PC=1.
REQ-039 Fetch 16'hB1FF (CMPI R1,-1) with alu_flags=5'b01000 -> alu_op=8'hBF, alu_b=16'h00FF, no rf_wr_en, psr=5'b01000.
REQ-040 Fetch 16'h0331 (XOR) after psr=5'b00010 -> rf_wr_en asserts and psr stays 5'b00010.
REQ-041 Hold imem_ack low for 5 cycles -> imem_req stays high and imem_addr stays stable; reset asserted in cycle 3 drops imem_req asynchronously and PC=RESET_PC.
REQ-042 PC=16'hFFFF with a NOP-class instruction 16'h4000 -> unsupported pulses; without the macro PC becomes 16'h0000; with CTRL_HALT_ON_ILLEGAL_EN, halted=1 and PC stays 16'hFFFF.
